div: RTL and testbench

Sequential 32-bit signed divider for the CPU's mult/div unit; it is the division counterpart of the Booth multiplier. It takes a dividend and divisor on a `start` pulse and runs a restoring shift-subtract algorithm, one quotient bit per cycle. It writes the quotient to `lo` and the remainder to `hi`, matching the HI/LO register convention. A one-cycle `done` pulse signals completion to the control unit, and divide-by-zero is flagged.

---
 rtl/div.sv | 99 +++++++++
 tb/tb_div.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Sequential 32-bit signed restoring divider: quotient to lo, remainder to hi.
// One quotient bit per cycle; done pulses once per completed or divide-by-zero request.
module div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] r;
  logic [31:0] q;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // The partial remainder never reaches 2^32 once stored, so its top bit lives
  // only in the shifted/trial values and is not kept in the register.
  always_comb begin
    shifted = {r, q[31]};
    trial   = shifted - {1'b0, dvs};
    mag_a   = dividend[31] ? -dividend : dividend;
    mag_b   = divisor[31]  ? -divisor  : divisor;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state    <= DONE;
              div_zero <= 1'b1;
            end else begin
              neg_q <= dividend[31] ^ divisor[31];
              neg_r <= dividend[31];
              q     <= mag_a;
              dvs   <= mag_b;
              r     <= '0;
              cnt   <= '0;
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!trial[32]) begin
            r <= trial[31:0];
            q <= {q[30:0], 1'b1};
          end else begin
            r <= shifted[31:0];
            q <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          lo    <= neg_q ? -q : q;
          hi    <= neg_r ? -r : r;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: cycle-level behavioural model plus directed literal checks.
module tb_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int tests = 0;
  int fails = 0;

  div dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  // Model: a request occupies the unit for 33 cycles, then results appear with done.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clock) begin
    longint a, b;
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0; m_dz = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        if (divisor == 32'd0) begin
          m_done = 1'b1; m_dz = 1'b1;
        end else begin
          a = longint'($signed(dividend));
          b = longint'($signed(divisor));
          p_lo = 32'(a / b);
          p_hi = 32'(a % b);
          m_left = 33;
        end
      end
    end
    chk_en = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("div_zero", 32'(div_zero), 32'(m_dz));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Issue one request and wait for done; lat counts negedges from the drive point.
  task automatic run(input logic [31:0] a, input logic [31:0] b, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    start = 1'b1; dividend = a; divisor = b;
    while (1) begin
      @(negedge clock);
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) break;
      if (lat > 60) begin
        tests++; fails++;
        $display("FAIL timeout: no done after %0d cycles, expected 34", lat);
        break;
      end
    end
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
    int lat, bc;
    run(a, b, lat, bc);
    check("lat", 32'(lat), 32'd34);
    check("lo_lit", lo, elo);
    check("hi_lit", hi, ehi);
  endtask

  initial begin
    int lat, bc, sawdone;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clock);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run(32'd100, 32'd7, lat, bc);
    check("lat_100_7", 32'(lat), 32'd34);
    check("busy_cycles", 32'(bc), 32'd33);
    check("lo_100_7", lo, 32'd14);
    check("hi_100_7", hi, 32'd2);
    @(negedge clock);
    check("done_once", 32'(done), 32'd0);

    directed(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    directed(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1);
    directed(-32'sd8, -32'sd4, 32'd2, 32'd0);
    directed(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    directed(32'd0, 32'd5, 32'd0, 32'd0);
    directed(32'd5, 32'd9, 32'd0, 32'd5);

    directed(32'd100, 32'd7, 32'd14, 32'd2);
    run(32'd123, 32'd0, lat, bc);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_hi", hi, 32'd2);
    check("dz_lo", lo, 32'd14);
    @(negedge clock);

    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clock); start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sawdone = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) sawdone++;
    end
    check("abort_nodone", 32'(sawdone), 32'd0);
    directed(32'd9, 32'd3, 32'd3, 32'd0);

    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(negedge clock); start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin @(negedge clock); lat++; end
    check("ign_done", 32'(done), 32'd1);
    check("ign_lo", lo, 32'd10);
    directed(32'd21, 32'd4, 32'd5, 32'd1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 9);
        3: rb = -32'($urandom_range(1, 9));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run(ra, rb, lat, bc);
      check("rnd_lat", 32'(lat), (rb == 32'd0) ? 32'd1 : 32'd34);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
